scalar_regfile_wr_arbiter: RTL

//  Shares the single write port of scalarRegisterFile among NUM_REQ writeback requesters
//    (default: req0 = ALU, req1 = memory load) using round-robin arbitration.

---
 rtl/scalar_regfile_wr_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/scalar_regfile_wr_arbiter.sv
// Round-robin arbiter sharing the scalar register file write port, plus a RAW-hazard scoreboard.
// Grant is combinational; the accepted write reaches the file one cycle later. Downstream never stalls.
module scalar_regfile_wr_arbiter #(
   parameter int registerSize     = 8,
   parameter int registerQuantity = 4,
   parameter int selectionBits    = 2,
   parameter int NUM_REQ          = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [NUM_REQ-1:0]                 req_valid,
   input  logic [NUM_REQ*selectionBits-1:0]   req_reg,
   input  logic [NUM_REQ*registerSize-1:0]    req_data,
   output logic [NUM_REQ-1:0]                 req_ready,
   input  logic                               rsv_valid,
   input  logic [selectionBits-1:0]           rsv_reg,
   input  logic [selectionBits-1:0]           rSel1,
   input  logic [selectionBits-1:0]           rSel2,
   output logic                               busy1,
   output logic                               busy2,
   output logic                               sb_err,
   output logic                               regWrEn,
   output logic [selectionBits-1:0]           regToWrite,
   output logic [registerSize-1:0]            dataIn
);

   localparam int PW  = $clog2(NUM_REQ);
   localparam int PW1 = PW + 1;

   logic [PW-1:0]               ptr_q, ptr_d;
   logic                        wr_en_q, wr_en_d;
   logic [selectionBits-1:0]    wr_reg_q, wr_reg_d;
   logic [registerSize-1:0]     wr_dat_q, wr_dat_d;
   logic [registerQuantity-1:0] sb_q, sb_d;
   logic                        err_q, err_d;

   logic                        grant_vld;
   logic [PW-1:0]               grant_idx;
   logic [PW1-1:0]              sum;
   logic                        xfer;

   // Scan requesters starting one past the last winner, wrapping modulo NUM_REQ.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      sum       = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         sum = {1'b0, ptr_q} + PW1'(k);
         if (sum >= PW1'(NUM_REQ)) sum = sum - PW1'(NUM_REQ);
         if (!grant_vld && req_valid[sum[PW-1:0]]) begin
            grant_vld = 1'b1;
            grant_idx = sum[PW-1:0];
         end
      end
      xfer      = grant_vld & reset;
      req_ready = '0;
      if (xfer) req_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      ptr_d    = ptr_q;
      wr_en_d  = xfer;
      wr_reg_d = wr_reg_q;
      wr_dat_d = wr_dat_q;
      if (xfer) begin
         ptr_d    = grant_idx;
         wr_reg_d = req_reg[grant_idx*selectionBits +: selectionBits];
         wr_dat_d = req_data[grant_idx*registerSize +: registerSize];
      end
   end

   // Reservation is applied after the commit clear so a same-cycle reserve wins.
   always_comb begin
      sb_d = sb_q;
      if (wr_en_q) sb_d[wr_reg_q] = 1'b0;
      if (rsv_valid) sb_d[rsv_reg] = 1'b1;
      err_d = err_q | (rsv_valid & sb_q[rsv_reg] & ~(wr_en_q && (wr_reg_q == rsv_reg)));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ptr_q    <= PW'(NUM_REQ - 1);
         wr_en_q  <= 1'b0;
         wr_reg_q <= '0;
         wr_dat_q <= '0;
         sb_q     <= '0;
         err_q    <= 1'b0;
      end else begin
         ptr_q    <= ptr_d;
         wr_en_q  <= wr_en_d;
         wr_reg_q <= wr_reg_d;
         wr_dat_q <= wr_dat_d;
         sb_q     <= sb_d;
         err_q    <= err_d;
      end
   end

   assign busy1      = sb_q[rSel1];
   assign busy2      = sb_q[rSel2];
   assign sb_err     = err_q;
   assign regWrEn    = wr_en_q;
   assign regToWrite = wr_reg_q;
   assign dataIn     = wr_dat_q;

endmodule
